avalon_burst_slave: RTL and testbench
=====================================

// Module: avalon_burst_slave
// PURPOSE
//  Parametrised Avalon-MM slave front end for the accelerator's local memory. Supports single and
//  burst writes and reads, range checking with error responses, and full-beat consumption on errors.
//  Sits between the Avalon fabric and the on-chip data RAM (1-cycle read latency).
// PARAMETERS
//  ADDR_W    13    address width, word addressed
//  DATA_W    32    data width
//  BURST_W   10    burstcount width
//  MAX_ADDR  4128  highest legal word address
//  MAX_BURST 512   longest legal burst, in beats
// PORTS
//  clk                 in   1        clock
//  n_rst               in   1        reset, asynchronous, active-low
//  read                in   1        Avalon read command
//  write               in   1        Avalon write command / write beat
//  beginbursttransfer  in   1        marks first cycle of a burst
//  burstcount          in   BURST_W  beats in burst; ignored (=1) when beginbursttransfer=0
//  address             in   ADDR_W   start word address
//  writedata           in   DATA_W   write beat data
//  waitrequest         out  1        slave stall
//  readdata            out  DATA_W   read beat data
//  readdatavalid       out  1        readdata/response valid
//  writeresponsevalid  out  1        write response valid
//  response            out  2        00=OKAY, 11=DECODEERROR
//  mem_addr            out  ADDR_W   RAM address
//  mem_wen / mem_ren   out  1        RAM write / read strobe
//  mem_wdata           out  DATA_W   RAM write data
//  mem_rdata           in   DATA_W   RAM read data, valid one cycle after mem_ren
// BEHAVIOUR
//  Reset: state=IDLE, beat count=0, err=0; every output 0 (waitrequest=0).
//  Mid-burst reset: immediate return to IDLE; no response is issued and no further mem strobes occur.
//  N = beginbursttransfer ? burstcount : 1.
//  err = N==0 | N>MAX_BURST | address+N-1>MAX_ADDR. Compute at ADDR_W+BURST_W bits; no wrap.
//  Command is accepted on the clk edge in IDLE with read|write asserted. write has priority over read.
//  IDLE: waitrequest=0.
//   - On a write, the accept cycle is beat 0. If !err: mem_wen=1, mem_addr=address, mem_wdata=writedata.
//     Latch base, N, err. Next state: N==1 -> WR_RESP, else WR_BEAT.
//   - On a read: latch base, N, err. Next state: RD_ISSUE.
//  WR_BEAT: waitrequest=0. Each cycle with write=1 is one beat.
//   - If !err: mem_wen=1, mem_addr=base+beat.
//   - If err: beats are consumed and discarded with no mem_wen.
//   - write=0 inserts an idle cycle; the beat count holds.
//   - After the beat with index N-1, go to WR_RESP.
//  WR_RESP: waitrequest=1; writeresponsevalid=1 for one cycle; response=err?11:00. Next state: IDLE.
//  RD_ISSUE: waitrequest=1. Lasts N cycles. If !err: mem_ren=1, mem_addr=base+i.
//   - One cycle after each issue cycle: readdatavalid=1, readdata=err?0:mem_rdata, response=err?11:00.
//   - After issue index N-1, go to RD_DRAIN.
//  RD_DRAIN: waitrequest=1; delivers the final read beat. Next state: IDLE.
//  Read latency: first readdatavalid arrives 2 cycles after the accept edge; beats then follow back-to-back.
//  The next command cannot be accepted before IDLE (back-to-back reads: one idle cycle between bursts).
// CONFIGURATION
//  AVS_RD_BURST_EN defined:     read bursts are fully supported as described above.
//  AVS_RD_BURST_EN not defined: a read with beginbursttransfer=1 and burstcount>1 forces err=1.
//   - The read still returns N beats with response=11 and readdata=0.
//   - Single reads are unaffected.
// STRUCTURE
//  Package avs_pkg holds:
//   - state_t enum {IDLE, WR_BEAT, WR_RESP, RD_ISSUE, RD_DRAIN}
//   - RESP_OKAY=2'b00 and RESP_DECERR=2'b11 constants
//  Beat counter: reuse flex_counter #(BURST_W) with rollover=N and clear on entry to IDLE.
//  Read-valid pipeline: a 1-stage register, kept inline.
// TESTING
//  1. Single write addr=5, data=0xA5A5 -> mem_wen@5 on the accept cycle; next cycle writeresponsevalid=1, response=00.
//  2. Write burst addr=100, N=4, write deasserted for 1 cycle after beat 1 -> writes to 100..103 in order;
//     one writeresponsevalid, response=00.
//  3. Write burst addr=4126, N=4 -> 4 beats accepted, no mem_wen; response=11.
//  4. Read burst addr=10, N=3, RAM preloaded 10..12 -> 3 consecutive readdatavalid with matching data,
//     first one 2 cycles after accept; response=00.
//  5. Single read at addr=5000 -> one readdatavalid, readdata=0, response=11.
//  6. n_rst asserted during beat 2 of an 8-beat write burst -> all outputs 0, IDLE;
//     a following single write completes normally. Repeat test 4 with AVS_RD_BURST_EN undefined -> 3 beats with response=11.

Source files
------------

// File: rtl/avs_pkg.sv
// Shared types and response codes for the Avalon-MM burst slave.
package avs_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_BEAT,
        WR_RESP,
        RD_ISSUE,
        RD_DRAIN
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/flex_counter.sv
// Beat counter: counts 0..rollover_val-1 on count_enable, wraps to 0 after the last index.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count_q, count_d;

    // Extra bit keeps count+1 from wrapping; a rollover of 0 flags on index 0.
    assign rollover_flag = ({1'b0, count_q} + 1'b1) >= {1'b0, rollover_val};
    assign count_out     = count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            count_d = rollover_flag ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) count_q <= '0;
        else        count_q <= count_d;
    end

endmodule

// File: rtl/avalon_burst_slave.sv
// Avalon-MM burst slave front end for the local data RAM (1-cycle read latency).
// Optional feature macro: AVS_RD_BURST_EN enables multi-beat read bursts.
module avalon_burst_slave
    import avs_pkg::*;
#(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 32,
    parameter int BURST_W   = 10,
    parameter int MAX_ADDR  = 4128,
    parameter int MAX_BURST = 512
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               read,
    input  logic               write,
    input  logic               beginbursttransfer,
    input  logic [BURST_W-1:0] burstcount,
    input  logic [ADDR_W-1:0]  address,
    input  logic [DATA_W-1:0]  writedata,
    output logic               waitrequest,
    output logic [DATA_W-1:0]  readdata,
    output logic               readdatavalid,
    output logic               writeresponsevalid,
    output logic [1:0]         response,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_wen,
    output logic               mem_ren,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata
);

    localparam int EW = ADDR_W + BURST_W;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [BURST_W-1:0]  n_q, n_d;
    logic                err_q, err_d;
    logic                rvalid_q, rvalid_d;
    logic                rerr_q, rerr_d;

    logic [BURST_W-1:0]  n_cmd;
    logic [EW-1:0]       end_excl;
    logic                rd_burst_err;
    logic                err_cmd;

    logic                cnt_clear, cnt_en, cnt_last;
    logic [BURST_W-1:0]  cnt_roll, beat;
    logic [1:0]          wr_resp;

    assign n_cmd    = beginbursttransfer ? burstcount : BURST_W'(1);
    assign end_excl = EW'(address) + EW'(n_cmd);

`ifdef AVS_RD_BURST_EN
    assign rd_burst_err = 1'b0;
`else
    assign rd_burst_err = !write && beginbursttransfer && (burstcount > BURST_W'(1));
`endif

    // address+N-1 > MAX_ADDR rewritten as address+N > MAX_ADDR+1 to avoid underflow.
    assign err_cmd = (n_cmd == '0) || (n_cmd > BURST_W'(MAX_BURST))
                  || (end_excl > EW'(MAX_ADDR + 1)) || rd_burst_err;

    flex_counter #(.NUM_CNT_BITS(BURST_W)) u_beat_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (cnt_clear),
        .count_enable (cnt_en),
        .rollover_val (cnt_roll),
        .count_out    (beat),
        .rollover_flag(cnt_last)
    );

    assign cnt_clear = (state_d == IDLE);

    always_comb begin
        state_d            = state_q;
        base_d             = base_q;
        n_d                = n_q;
        err_d              = err_q;
        rvalid_d           = 1'b0;
        rerr_d             = err_q;
        cnt_en             = 1'b0;
        cnt_roll           = n_q;
        waitrequest        = 1'b0;
        mem_wen            = 1'b0;
        mem_ren            = 1'b0;
        mem_addr           = '0;
        mem_wdata          = '0;
        writeresponsevalid = 1'b0;
        wr_resp            = RESP_OKAY;

        case (state_q)
            IDLE: begin
                cnt_roll = n_cmd;
                if (write) begin
                    base_d = address;
                    n_d    = n_cmd;
                    err_d  = err_cmd;
                    cnt_en = 1'b1;
                    if (!err_cmd) begin
                        mem_wen   = 1'b1;
                        mem_addr  = address;
                        mem_wdata = writedata;
                    end
                    // The accept beat alone completes a zero- or one-beat write.
                    state_d = (n_cmd <= BURST_W'(1)) ? WR_RESP : WR_BEAT;
                end else if (read) begin
                    base_d  = address;
                    n_d     = n_cmd;
                    err_d   = err_cmd;
                    state_d = RD_ISSUE;
                end
            end
            WR_BEAT: begin
                if (write) begin
                    cnt_en = 1'b1;
                    if (!err_q) begin
                        mem_wen   = 1'b1;
                        mem_addr  = base_q + ADDR_W'(beat);
                        mem_wdata = writedata;
                    end
                    if (cnt_last) state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                waitrequest        = 1'b1;
                writeresponsevalid = 1'b1;
                wr_resp            = err_q ? RESP_DECERR : RESP_OKAY;
                state_d            = IDLE;
            end
            RD_ISSUE: begin
                waitrequest = 1'b1;
                cnt_en      = 1'b1;
                rvalid_d    = 1'b1;
                if (!err_q) begin
                    mem_ren  = 1'b1;
                    mem_addr = base_q + ADDR_W'(beat);
                end
                if (cnt_last) state_d = RD_DRAIN;
            end
            RD_DRAIN: begin
                waitrequest = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        readdatavalid = rvalid_q;
        readdata      = (rvalid_q && !rerr_q) ? mem_rdata : '0;
        if (writeresponsevalid)      response = wr_resp;
        else if (rvalid_q && rerr_q) response = RESP_DECERR;
        else                         response = RESP_OKAY;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            base_q   <= '0;
            n_q      <= '0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            n_q      <= n_d;
            err_q    <= err_d;
            rvalid_q <= rvalid_d;
            rerr_q   <= rerr_d;
        end
    end

endmodule

// File: tb/tb_avalon_burst_slave.sv
// Directed, table-driven bench for avalon_burst_slave with a behavioural 1-cycle RAM.
module tb_avalon_burst_slave;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        read, write, beginbursttransfer;
    logic [9:0]  burstcount;
    logic [12:0] address;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        writeresponsevalid;
    logic [1:0]  response;
    logic [12:0] mem_addr;
    logic        mem_wen, mem_ren;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

`ifdef AVS_RD_BURST_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    always #5 clk = ~clk;

    avalon_burst_slave dut (
        .clk               (clk),
        .n_rst             (n_rst),
        .read              (read),
        .write             (write),
        .beginbursttransfer(beginbursttransfer),
        .burstcount        (burstcount),
        .address           (address),
        .writedata         (writedata),
        .waitrequest       (waitrequest),
        .readdata          (readdata),
        .readdatavalid     (readdatavalid),
        .writeresponsevalid(writeresponsevalid),
        .response          (response),
        .mem_addr          (mem_addr),
        .mem_wen           (mem_wen),
        .mem_ren           (mem_ren),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata)
    );

    // RAM model: unwritten words read back as 0xD000_0000 | address.
    logic [31:0] ram     [0:8191];
    bit          written [0:8191];

    always @(posedge clk) begin
        if (mem_wen) begin
            ram[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
        if (mem_ren)
            mem_rdata <= written[mem_addr] ? ram[mem_addr] : (32'hD000_0000 | {19'd0, mem_addr});
    end

    logic [83:0] got_bus;
    assign got_bus = {waitrequest, mem_wen, mem_ren, mem_addr, mem_wdata,
                      readdatavalid, readdata, writeresponsevalid, response};

    typedef struct {
        logic        rd, wr, bbt;
        logic [9:0]  bc;
        logic [12:0] addr;
        logic [31:0] wd;
        logic [83:0] exp;
    } vec_t;

    localparam int NV = 30;
    vec_t vecs [NV];

    function automatic vec_t mk(bit rd, bit wr, bit bbt, int bc, int addr, logic [31:0] wd,
                                bit ew, bit ewen, bit eren, int emaddr, logic [31:0] emwd,
                                bit erdv, logic [31:0] erd, bit ewrv, logic [1:0] eresp);
        vec_t v;
        v.rd   = rd;
        v.wr   = wr;
        v.bbt  = bbt;
        v.bc   = 10'(bc);
        v.addr = 13'(addr);
        v.wd   = wd;
        v.exp  = {ew, ewen, eren, 13'(emaddr), emwd, erdv, erd, ewrv, eresp};
        return v;
    endfunction

    task automatic drive(bit rd, bit wr, bit bbt, logic [9:0] bc, logic [12:0] addr, logic [31:0] wd);
        read               = rd;
        write              = wr;
        beginbursttransfer = bbt;
        burstcount         = bc;
        address            = addr;
        writedata          = wd;
    endtask

    task automatic check_bus(string name, logic [83:0] exp);
        checks++;
        if (got_bus !== exp) begin
            errors++;
            $display("FAIL %s: got wait/wen/ren/addr/wdata/rdv/rdata/wrv/resp=%h expected %h",
                     name, got_bus, exp);
        end
    endtask

    task automatic check_val(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        int cyc;
        logic [31:0] first_rd;
        logic [1:0]  first_resp;

        // single write, then write burst with a stall after beat 1
        vecs[0]  = mk(0,1,0,0,5,32'hA5A5,   0,1,0,5,32'hA5A5,   0,0,0,2'b00);
        vecs[1]  = mk(0,0,0,0,0,0,          1,0,0,0,0,          0,0,1,2'b00);
        vecs[2]  = mk(0,1,1,4,100,32'h100,  0,1,0,100,32'h100,  0,0,0,2'b00);
        vecs[3]  = mk(0,1,0,0,0,32'h101,    0,1,0,101,32'h101,  0,0,0,2'b00);
        vecs[4]  = mk(0,0,0,0,0,0,          0,0,0,0,0,          0,0,0,2'b00);
        vecs[5]  = mk(0,1,0,0,0,32'h102,    0,1,0,102,32'h102,  0,0,0,2'b00);
        vecs[6]  = mk(0,1,0,0,0,32'h103,    0,1,0,103,32'h103,  0,0,0,2'b00);
        vecs[7]  = mk(0,0,0,0,0,0,          1,0,0,0,0,          0,0,1,2'b00);
        // out-of-range burst write: beats consumed, nothing written
        vecs[8]  = mk(0,1,1,4,4126,32'h1,   0,0,0,0,0,          0,0,0,2'b00);
        vecs[9]  = mk(0,1,0,0,0,32'h2,      0,0,0,0,0,          0,0,0,2'b00);
        vecs[10] = mk(0,1,0,0,0,32'h3,      0,0,0,0,0,          0,0,0,2'b00);
        vecs[11] = mk(0,1,0,0,0,32'h4,      0,0,0,0,0,          0,0,0,2'b00);
        vecs[12] = mk(0,0,0,0,0,0,          1,0,0,0,0,          0,0,1,2'b11);
        // 3-beat read at 10
        vecs[13] = mk(1,0,1,3,10,0,         0,0,0,0,0,          0,0,0,2'b00);
        vecs[14] = mk(0,0,0,0,0,0,          1,0,RB,RB?10:0,0,   0,0,0,2'b00);
        vecs[15] = mk(0,0,0,0,0,0,          1,0,RB,RB?11:0,0,   1,RB?32'hD000_000A:32'h0,0,RB?2'b00:2'b11);
        vecs[16] = mk(0,0,0,0,0,0,          1,0,RB,RB?12:0,0,   1,RB?32'hD000_000B:32'h0,0,RB?2'b00:2'b11);
        vecs[17] = mk(0,0,0,0,0,0,          1,0,0,0,0,          1,RB?32'hD000_000C:32'h0,0,RB?2'b00:2'b11);
        vecs[18] = mk(0,0,0,0,0,0,          0,0,0,0,0,          0,0,0,2'b00);
        // out-of-range single read
        vecs[19] = mk(1,0,0,0,5000,0,       0,0,0,0,0,          0,0,0,2'b00);
        vecs[20] = mk(0,0,0,0,0,0,          1,0,0,0,0,          0,0,0,2'b00);
        vecs[21] = mk(0,0,0,0,0,0,          1,0,0,0,0,          1,0,0,2'b11);
        vecs[22] = mk(0,0,0,0,0,0,          0,0,0,0,0,          0,0,0,2'b00);
        // single write at the highest legal address
        vecs[23] = mk(0,1,0,0,4128,32'h77,  0,1,0,4128,32'h77,  0,0,0,2'b00);
        vecs[24] = mk(0,0,0,0,0,0,          1,0,0,0,0,          0,0,1,2'b00);
        // zero-length burst is an error
        vecs[25] = mk(0,1,1,0,7,32'h88,     0,0,0,0,0,          0,0,0,2'b00);
        vecs[26] = mk(0,0,0,0,0,0,          1,0,0,0,0,          0,0,1,2'b11);
        // 2-beat burst ending exactly at the highest legal address
        vecs[27] = mk(0,1,1,2,4127,32'h55,  0,1,0,4127,32'h55,  0,0,0,2'b00);
        vecs[28] = mk(0,1,0,0,0,32'h56,     0,1,0,4128,32'h56,  0,0,0,2'b00);
        vecs[29] = mk(0,0,0,0,0,0,          1,0,0,0,0,          0,0,1,2'b00);

        drive(0,0,0,0,0,0);
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_bus("reset", 84'd0);
        n_rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].rd, vecs[i].wr, vecs[i].bbt, vecs[i].bc, vecs[i].addr, vecs[i].wd);
            #1;
            check_bus($sformatf("vec%0d", i), vecs[i].exp);
        end

        // reset during beat 2 of an 8-beat write burst
        @(negedge clk); drive(0,1,1,8,200,32'h200);
        @(negedge clk); drive(0,1,0,0,0,32'h201);
        @(negedge clk); drive(0,0,0,0,0,0); n_rst = 1'b0;
        #1;
        check_bus("mid_burst_reset", 84'd0);
        @(posedge clk);
        @(negedge clk);
        check_bus("reset_held", 84'd0);
        n_rst = 1'b1;
        @(negedge clk); drive(0,1,0,0,300,32'hBEEF);
        #1;
        check_bus("post_reset_wr", {1'b0,1'b1,1'b0,13'd300,32'hBEEF,1'b0,32'd0,1'b0,2'b00});
        @(negedge clk); drive(0,0,0,0,0,0);
        #1;
        check_bus("post_reset_resp", {1'b1,1'b0,1'b0,13'd0,32'd0,1'b0,32'd0,1'b1,2'b00});
        @(negedge clk);
        check_val("ram200", written[200] ? ram[200] : 32'hFFFF_FFFF, 32'h200);
        check_val("ram201", written[201] ? ram[201] : 32'hFFFF_FFFF, 32'h201);
        check_val("ram202_untouched", {31'd0, written[202]}, 32'd0);
        check_val("ram300", written[300] ? ram[300] : 32'hFFFF_FFFF, 32'hBEEF);
        check_val("ram103", written[103] ? ram[103] : 32'hFFFF_FFFF, 32'h103);
        check_val("ram4128", written[4128] ? ram[4128] : 32'hFFFF_FFFF, 32'h56);
        check_val("ram4126_untouched", {31'd0, written[4126]}, 32'd0);

        // first-beat read latency, bounded wait
        @(negedge clk); drive(1,0,1,2,20,0);
        cyc = 0;
        first_rd = 32'hFFFF_FFFF;
        first_resp = 2'bxx;
        while (cyc < 10) begin
            @(negedge clk);
            drive(0,0,0,0,0,0);
            cyc++;
            #1;
            if (readdatavalid) begin
                first_rd = readdata;
                first_resp = response;
                break;
            end
        end
        check_val("rd_latency", cyc, 2);
        check_val("rd_first_data", first_rd, RB ? 32'hD000_0014 : 32'h0);
        check_val("rd_first_resp", {30'd0, first_resp}, RB ? 32'd0 : 32'd3);
        @(negedge clk);
        #1;
        check_val("rd_second_valid", {31'd0, readdatavalid}, 32'd1);
        check_val("rd_second_data", readdata, RB ? 32'hD000_0015 : 32'h0);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
